// File: rtl/nibble_add_seq_if.sv
// rtl/nibble_add_seq_if.sv - operand/result bundle for the nibble-serial adder
// NIBBLE_ADD_SEQ_SUB_EN adds the sub select line.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, s, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, s, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, s, cout, ovf);
`endif
endinterface

// File: rtl/nibble_add_seq.sv
// rtl/nibble_add_seq.sv - W-bit adder built from one 4-bit ripple slice reused per cycle
// NIBBLE_ADD_SEQ_SUB_EN enables A-B via the sub select.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign co = c[4];
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    nibble_add_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic          last_slice;
    logic [W-1:0]  a_q, b_q, shadow, s_q, result, b_eff;
    logic          carry, cout_q, ovf_q, c0;
    logic [CW-1:0] cnt;
    logic [3:0]    sl_a, sl_b, sl_s;
    logic          sl_co;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1; the user carry-in is ignored in that mode.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff = bus.b;
    assign c0    = bus.cin;
`endif

    assign last_slice = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sl_a = a_q[4*cnt +: 4];
    assign sl_b = b_q[4*cnt +: 4];

    ripple_carry_adder u_rca (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry),
        .s  (sl_s),
        .co (sl_co)
    );

    // The top slice is still in flight at the final edge, so splice it in directly.
    always_comb begin
        result          = shadow;
        result[W-1 -: 4] = sl_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            shadow <= '0;
            s_q    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                a_q   <= bus.a;
                b_q   <= b_eff;
                carry <= c0;
                cnt   <= '0;
            end
            if (state == RUN) begin
                shadow[4*cnt +: 4] <= sl_s;
                carry              <= sl_co;
                cnt                <= cnt + 1'b1;
                if (last_slice) begin
                    s_q    <= result;
                    cout_q <= sl_co;
                    ovf_q  <= (a_q[W-1] == b_q[W-1]) && (result[W-1] != a_q[W-1]);
                end
            end
        end
    end

    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 A  input  W  operand A, captured on accepted start.
REQ-006 B  input  W  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 sub  input  1  subtract select, captured on accepted start; present only with SUB_EN.
REQ-009 busy  output  1  high while slices are being computed.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 S  output  W  registered sum.
REQ-012 cout  output  1  registered carry-out of the top slice.
REQ-013 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-014 The block shall compute the W-bit sum by time-multiplexing one instance of the team's existing 4-bit ripple_carry_adder, one slice per cycle, least-significant slice first.
REQ-015 FSM states: IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after slice NIBBLES-1 is registered; DONE->RUN on start=1, else DONE->IDLE.
REQ-016 Accepted start at edge E0: A, B and cin (and sub) are registered, slice counter is cleared to 0, and busy=1 from E0.
REQ-017 At edge E(i+1), i=0..NIBBLES-1: slice i sum is written to a shadow register and slice i carry-out is saved as the carry-in for slice i+1; the captured cin feeds slice 0.
REQ-018 At edge E(NIBBLES): S, cout and ovf are loaded from the shadow result; busy=0 and done=1 for exactly one cycle.
REQ-019 S, cout and ovf shall change only at the RUN->DONE edge and hold their values otherwise, including while a new operation runs.
REQ-020 ovf = (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]), where Beff is the effective B operand.
REQ-021 start while busy=1 shall be ignored, with no effect on operands or timing.
REQ-022 start in DONE shall be accepted: back-to-back operations need no idle cycle, and done pulses once per operation.
REQ-023 Operand inputs are don't-care except at the accepted-start edge.
REQ-024 Latency: done is high in the cycle after edge E(NIBBLES), i.e. NIBBLES+1 cycles after the start-sampling edge.

Reset
REQ-025 rst=1 at a clock edge shall force IDLE, busy=0, done=0, S=0, cout=0, ovf=0, slice counter=0 and the saved carry to 0.
REQ-026 Reset asserted mid-RUN shall abort the operation: no done pulse, and S, cout and ovf read 0.
REQ-027 If rst and start are both high at the same edge, rst wins and start is dropped.

Configuration
REQ-028 Macro NIBBLE_ADD_SEQ_SUB_EN, when defined, shall add the sub port; sub=1 captured gives Beff = ~B with slice-0 carry-in forced to 1, cin ignored, and the result is A-B.
REQ-029 With NIBBLE_ADD_SEQ_SUB_EN undefined, the sub port and its logic shall be absent; Beff = B and the block is add-only.

Verification (NIBBLES=4)
REQ-030 A=0x1234, B=0x4321, cin=0, start pulse -> S=0x5555, cout=0, ovf=0; done high exactly 5 cycles after the start-sampling edge; busy high for 4 cycles.
REQ-031 A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1, ovf=0; the carry propagates through all 4 slices.
REQ-032 A=0x7FFF, B=0x0001 -> S=0x8000, cout=0, ovf=1; a second start pulsed during busy is ignored, and done pulses once.
REQ-033 Two starts back-to-back, the second issued in DONE (0x0001+0x0001, then 0x00FF+0x0001) -> done pulses 5 cycles apart; S=0x0002 then S=0x0100; S holds 0x0002 during the second run.
REQ-034 rst raised 2 cycles into RUN -> no done pulse; all outputs read 0; a subsequent start works normally.
REQ-035 With SUB_EN: A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, cout=0, ovf=0; A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, ovf=1.
